// File: rtl/circle_seq_ctrl.sv
// Van der Corput circle sequencer: issues bit-reversed k angles to a CORDIC and emits (cos, sin, k) points.
// One point per CORDIC latency + 3 cycles; a stalled out_ready holds the point and blocks the next issue.
module circle_seq_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [15:0]       seed,
  input  logic              go,
  input  logic [CNT_W-1:0]  num_pts,
  input  logic              abort,
  output logic              busy,
  output logic              cordic_start,
  output logic [15:0]       cordic_angle,
  input  logic              cordic_ready,
  input  logic              cordic_done,
  input  logic [DATA_W-1:0] cordic_cos,
  input  logic [DATA_W-1:0] cordic_sin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_x,
  output logic [DATA_W-1:0] out_y,
  output logic [15:0]       out_index,
  output logic              out_last
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

  state_t           state;
  logic [15:0]      k;
  logic [CNT_W-1:0] remaining;

  function automatic logic [15:0] bitrev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      k            <= '0;
      remaining    <= '0;
      cordic_start <= 1'b0;
      cordic_angle <= '0;
      out_valid    <= 1'b0;
      out_x        <= '0;
      out_y        <= '0;
      out_index    <= '0;
      out_last     <= 1'b0;
    end else if (abort) begin
      // k survives an abort so the sequence can resume where it stopped
      state        <= S_IDLE;
      remaining    <= '0;
      cordic_start <= 1'b0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
    end else begin
      cordic_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (seed_load) k <= seed;
          if (go && (num_pts != '0)) begin
            remaining <= num_pts;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cordic_ready) begin
            cordic_start <= 1'b1;
            cordic_angle <= bitrev16(k);
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cordic_done) begin
            out_x     <= cordic_cos;
            out_y     <= cordic_sin;
            out_index <= k;
            out_last  <= (remaining == CNT_W'(1));
            out_valid <= 1'b1;
            k         <= k + 16'd1;
            remaining <= remaining - CNT_W'(1);
            state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= (remaining == '0) ? S_IDLE : S_ISSUE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_circle_seq_ctrl.sv
// Directed + randomized bench for circle_seq_ctrl with a latency-randomized CORDIC responder and a point scoreboard.
module tb_circle_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, seed_load = 1'b0, go = 1'b0, abort = 1'b0;
  logic [15:0] seed = '0;
  logic [15:0] num_pts = '0;
  logic        cordic_ready = 1'b0, cordic_done = 1'b0, out_ready = 1'b0;
  logic [31:0] cordic_cos = '0, cordic_sin = '0;
  logic        busy, cordic_start, out_valid, out_last;
  logic [15:0] cordic_angle, out_index;
  logic [31:0] out_x, out_y;

  circle_seq_ctrl dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .go(go),
    .num_pts(num_pts), .abort(abort), .busy(busy), .cordic_start(cordic_start),
    .cordic_angle(cordic_angle), .cordic_ready(cordic_ready), .cordic_done(cordic_done),
    .cordic_cos(cordic_cos), .cordic_sin(cordic_sin), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_index(out_index),
    .out_last(out_last)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [15:0] idx;
    logic        last;
  } pt_t;

  int          checks = 0, failures = 0;
  pt_t         exp_q[$];
  logic [15:0] ang_q[$];
  logic [15:0] k_model = '0;
  logic [15:0] cur_ang = '0;
  bit          pending = 0, pend_dead = 0, start_prev = 0, ready_hold = 0, rand_rdy = 0;
  int          lat_cnt = 0, force_lat = 0, start_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Unit-circle reference scaled to 2^30; angle 0x10000 is one full turn.
  function automatic logic [31:0] cos_m(input logic [15:0] a);
    real th;
    th = 6.283185307179586 * real'(a) / 65536.0;
    return $rtoi($cos(th) * 1073741824.0);
  endfunction

  function automatic logic [31:0] sin_m(input logic [15:0] a);
    real th;
    th = 6.283185307179586 * real'(a) / 65536.0;
    return $rtoi($sin(th) * 1073741824.0);
  endfunction

  task automatic plan(input logic [15:0] k0, input int n);
    logic [15:0] kk, a;
    pt_t p;
    for (int i = 0; i < n; i++) begin
      kk = k0 + 16'(i);
      a  = {<<{kk}};
      ang_q.push_back(a);
      p.x = cos_m(a); p.y = sin_m(a); p.idx = kk; p.last = (i == n - 1);
      exp_q.push_back(p);
    end
  endtask

  task automatic tick();
    bit  hs, done_was, dead_was, last_hs;
    pt_t e;
    hs = out_valid && out_ready;
    last_hs = 0;
    if (hs) begin
      if (exp_q.size() == 0) chk("point_expected", 64'd0, 64'd1);
      else begin
        e = exp_q.pop_front();
        chk("out_x", 64'(out_x), 64'(e.x));
        chk("out_y", 64'(out_y), 64'(e.y));
        chk("out_index", 64'(out_index), 64'(e.idx));
        chk("out_last", 64'(out_last), 64'(e.last));
        last_hs = e.last;
      end
    end
    done_was = cordic_done;
    dead_was = pend_dead;
    @(posedge clk); #1;
    if (done_was) begin
      chk("valid_after_done", 64'(out_valid), 64'(!dead_was));
      if (!dead_was) k_model++;
    end
    if (hs) begin
      chk("valid_drop_after_hs", 64'(out_valid), 64'd0);
      chk("no_start_after_hs", 64'(cordic_start), 64'd0);
      if (last_hs) chk("busy_fall_on_last", 64'(busy), 64'd0);
    end
    if (cordic_start) begin
      start_cnt++;
      chk("start_one_cycle", 64'(start_prev), 64'd0);
      if (ang_q.size() == 0) chk("start_expected", 64'd0, 64'd1);
      else chk("cordic_angle", 64'(cordic_angle), 64'(ang_q.pop_front()));
      pending = 1; pend_dead = 0; cur_ang = cordic_angle;
      lat_cnt = $urandom_range(0, 3) + force_lat;
    end
    start_prev = cordic_start;
    if (cordic_done) begin
      cordic_done = 0; pending = 0;
    end else if (pending && !cordic_start) begin
      if (lat_cnt == 0) cordic_done = 1;
      else lat_cnt--;
    end
    if (cordic_done) begin
      cordic_cos = cos_m(cur_ang); cordic_sin = sin_m(cur_ang);
    end else begin
      cordic_cos = $urandom; cordic_sin = $urandom;
    end
    cordic_ready = !pending && !ready_hold;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic start_burst(input bit ld, input logic [15:0] sd, input int n);
    if (ld) begin
      seed_load = 1; seed = sd; k_model = sd;
    end
    go = 1; num_pts = 16'(n);
    plan(k_model, n);
    tick();
    go = 0; seed_load = 0;
    chk("busy_after_go", 64'(busy), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (!(!busy && exp_q.size() == 0 && !pending && !cordic_done) && t < budget) begin
      tick(); t++;
    end
    chk("idle_reached", 64'(!busy && exp_q.size() == 0 && !pending), 64'd1);
    chk("angles_consumed", 64'(ang_q.size()), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_start"}, 64'(cordic_start), 64'd0);
    chk({tag, "_angle"}, 64'(cordic_angle), 64'd0);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_x"}, 64'(out_x), 64'd0);
    chk({tag, "_y"}, 64'(out_y), 64'd0);
    chk({tag, "_index"}, 64'(out_index), 64'd0);
    chk({tag, "_last"}, 64'(out_last), 64'd0);
  endtask

  initial begin
    int sc, t;
    logic [31:0] sx, sy;
    logic [15:0] si;

    repeat (3) tick();
    chk_zero("reset");
    rst = 0;
    out_ready = 1;

    // Seed 0 burst of 4, with go/seed_load injected mid-burst.
    start_burst(0, 16'h0000, 4);
    tick();
    chk("start_latency", 64'(cordic_start), 64'd1);
    go = 1; seed_load = 1; seed = 16'h1234; num_pts = 16'd7;
    tick();
    go = 0; seed_load = 0;
    wait_idle(200);

    start_burst(1, 16'h0003, 2);
    wait_idle(200);
    start_burst(1, 16'hFFFF, 2);
    wait_idle(200);

    // Output backpressure for 5 cycles.
    out_ready = 0;
    start_burst(1, 16'h0010, 2);
    t = 0;
    while (!out_valid && t < 50) begin tick(); t++; end
    chk("bp_valid_seen", 64'(out_valid), 64'd1);
    sx = out_x; sy = out_y; si = out_index; sc = start_cnt;
    repeat (5) begin
      tick();
      chk("bp_x_stable", 64'(out_x), 64'(sx));
      chk("bp_y_stable", 64'(out_y), 64'(sy));
      chk("bp_index_stable", 64'(out_index), 64'(si));
      chk("bp_valid_held", 64'(out_valid), 64'd1);
      chk("bp_no_start", 64'(start_cnt), 64'(sc));
    end
    out_ready = 1;
    wait_idle(200);
    chk("bp_one_start_after", 64'(start_cnt), 64'(sc + 1));

    // CORDIC not ready for 7 cycles in ISSUE.
    ready_hold = 1; cordic_ready = 0;
    start_burst(0, 16'h0000, 1);
    sc = start_cnt;
    repeat (7) begin
      tick();
      chk("hold_no_start", 64'(cordic_start), 64'd0);
    end
    ready_hold = 0; cordic_ready = 1;
    wait_idle(200);
    chk("hold_one_start", 64'(start_cnt), 64'(sc + 1));

    // go with zero points is ignored.
    sc = start_cnt;
    go = 1; num_pts = 16'd0;
    tick();
    go = 0;
    repeat (3) begin
      tick();
      chk("zero_pts_busy", 64'(busy), 64'd0);
    end
    chk("zero_pts_no_start", 64'(start_cnt), 64'(sc));

    // Randomized bursts with random downstream readiness.
    rand_rdy = 1;
    for (int r = 0; r < 6; r++) begin
      start_burst(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(1, 5));
      wait_idle(400);
    end
    rand_rdy = 0; out_ready = 1;

    // Abort while waiting for the CORDIC result.
    force_lat = 5;
    start_burst(1, 16'($urandom), 3);
    sc = start_cnt; t = 0;
    while (start_cnt == sc && t < 50) begin tick(); t++; end
    chk("abort_start_seen", 64'(start_cnt), 64'(sc + 1));
    abort = 1; pend_dead = 1;
    tick();
    abort = 0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(out_valid), 64'd0);
    ang_q.delete(); exp_q.delete();
    repeat (12) tick();
    chk("abort_stays_idle", 64'(busy), 64'd0);
    chk("abort_no_more_start", 64'(start_cnt), 64'(sc + 1));
    force_lat = 0;
    start_burst(0, 16'h0000, 2);
    wait_idle(200);

    // Reset in the middle of a burst.
    start_burst(1, 16'($urandom), 3);
    t = 0;
    while (exp_q.size() > 2 && t < 100) begin tick(); t++; end
    chk("mid_rst_progress", 64'(exp_q.size()), 64'd2);
    rst = 1; pend_dead = 1;
    tick();
    rst = 0;
    chk_zero("mid_rst");
    k_model = '0;
    ang_q.delete(); exp_q.delete();
    t = 0;
    while ((pending || cordic_done) && t < 50) begin tick(); t++; end
    start_burst(0, 16'h0000, 1);
    wait_idle(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/circle_seq_ctrl.md
# circle_seq_ctrl

Upstream sequencer for `cordic_trig_16bit`. It generates base-2 van der Corput angles (the bit-reversed index k) and issues them one at a time over the CORDIC `start`/`ready`/`done` handshake. It captures each cosine/sine result and presents it as a point on the unit circle through a valid/ready output port. A single `go` runs a burst of `num_pts` points of the low-discrepancy circle sequence.

## Interface
- `DATA_W`, default 32: width of CORDIC cosine/sine and of the output x/y.
- `CNT_W`, default 16: width of `num_pts` and of the internal remaining-points counter.

Ports:
- `clk`, in, 1: clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `seed_load`, in, 1: load `seed` into index k; honoured only in IDLE.
- `seed`, in, 16: new value for k.
- `go`, in, 1: start a burst; honoured only in IDLE.
- `num_pts`, in, CNT_W: number of points in the burst, sampled with `go`.
- `abort`, in, 1: stop the burst; return to IDLE.
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `cordic_start`, out, 1: one-cycle request pulse to the CORDIC.
- `cordic_angle`, out, 16: angle presented to the CORDIC; equals bitrev16(k).
- `cordic_ready`, in, 1: CORDIC can accept a request.
- `cordic_done`, in, 1: CORDIC result is valid.
- `cordic_cos`, in, DATA_W: CORDIC cosine result.
- `cordic_sin`, in, DATA_W: CORDIC sine result.
- `out_valid`, out, 1: output point is valid.
- `out_ready`, in, 1: downstream accepts the point.
- `out_x`, out, DATA_W: captured cosine.
- `out_y`, out, DATA_W: captured sine.
- `out_index`, out, 16: value of k that produced the point.
- `out_last`, out, 1: marks the final point of the burst.

## Operation
- Reset: state IDLE, k=0, remaining=0; every output is 0.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - `seed_load` sets k=`seed`.
  - `go` with `num_pts`≠0 sets remaining=`num_pts` and moves to ISSUE.
  - `go` with `num_pts`=0 is ignored.
  - `seed_load` and `go` in the same cycle: the seed applies first, so the first angle uses the new seed.
- ISSUE: on a cycle with `cordic_ready`=1:
  - `cordic_start` goes high for exactly one cycle.
  - `cordic_angle` is loaded with bitrev16(k), i.e. angle bit i = k bit 15−i.
  - The FSM moves to WAIT.
- WAIT: on the first cycle with `cordic_done`=1:
  - Capture `out_x`=`cordic_cos`, `out_y`=`cordic_sin` and `out_index`=k.
  - Set `out_last`=(remaining==1) and `out_valid`=1.
  - Update k=k+1 (mod 2^16) and remaining=remaining−1.
  - Move to OUT.
- OUT: hold all outputs stable until `out_valid`&&`out_ready`. After the handshake, go to IDLE if remaining==0, otherwise back to ISSUE.
- `cordic_angle` holds its value from the start pulse until the next issue.
- `cordic_done` outside WAIT is ignored. `seed_load` and `go` while busy are ignored.
- `abort` (any state) returns the FSM to IDLE on the next edge:
  - `out_valid`, `out_last` and `cordic_start` clear to 0.
  - k keeps its current value; remaining clears.
  - A CORDIC result still in flight is dropped. The next ISSUE waits for `cordic_ready`.
- `rst` mid-burst is identical to power-on reset and has priority over `abort`, `go` and `seed_load`.
- The block does no arithmetic on the data path; x and y pass through unchanged (signed, DATA_W).

## Timing
- `go` sampled at edge N:
  - `busy`=1 after edge N.
  - With `cordic_ready` high at edge N+1, `cordic_start`=1 for cycle N+1 to N+2 only.
- `cordic_done` sampled at edge M: `out_valid`=1 after edge M.
- Output handshake at edge P:
  - `out_valid`=0 after edge P.
  - The next `cordic_start` is asserted after edge P+1 at the earliest (requires `cordic_ready`).
- Throughput: one point per (CORDIC latency + 3 cycles) when there is no backpressure.
- `busy` falls on the edge that completes the last output handshake.

## Test plan
- Seed 0, `go` with `num_pts`=4, CORDIC model always ready:
  - `cordic_angle` sequence is 0x0000, 0x8000, 0x4000, 0xC000.
  - `out_index` is 0..3; `out_last` is high only on the 4th point.
  - `out_x`/`out_y` match the model (0x4000 gives cos≈0, sin≈+1).
- `seed_load` 0x0003 together with `go` `num_pts`=2: angles are 0xC000 then 0x2000; `out_index` is 3 then 4.
- Wrap-around: seed 0xFFFF, `num_pts`=2: angles 0xFFFF then 0x0000; `out_index` 0xFFFF then 0x0000.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid`:
  - x/y/index stay stable.
  - No `cordic_start` is issued during the stall.
  - Exactly one start follows, after release.
- Handshake corner cases:
  - `cordic_ready`=0 for 7 cycles in ISSUE: no start until ready rises, then exactly one 1-cycle pulse.
  - `go` with `num_pts`=0: `busy` stays 0 and no start is issued.
  - `go` while busy: ignored.
- `abort` in WAIT:
  - `busy`=0 on the next cycle, `out_valid` never rises, and a late `cordic_done` is ignored.
  - `rst` mid-burst: all outputs return to 0 and k=0.
